branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Branch target predictor for the IF stage. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it turns the fetch PC into the predicted next PC, which the pipeline carries as `predicted_ifid_pc` / `predicted_idex_pc`. When `control_unit` detects a misprediction it raises `bpu_write_en`, and the predictor trains on the resolved branch in EX/MEM.

## Interface
Parameters:
- `IDX_W`, default 4: BTB index width; the BTB has 2^IDX_W entries.
- `TAG_W`, default 26: tag width, equal to 32 − IDX_W − 2.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `if_pc`  in  32: PC of the instruction being fetched.
- `bpu_predicted_pc`  out  32: predicted next fetch PC.
- `bpu_hit`  out  1: BTB entry valid and tag matches `if_pc`.
- `bpu_write_en`  in  1: training strobe from `control_unit`.
- `mem_stall`  in  1: memory stall; suppresses training.
- `exmem_pc`  in  32: PC of the resolved instruction.
- `exmem_target`  in  32: resolved taken-target of that instruction.
- `exmem_is_branch`  in  1: the resolved instruction is a conditional branch.
- `exmem_taken`  in  1: the branch resolved as taken.
- `bpu_lookup_cnt`  out  32: number of non-stalled lookups.
- `bpu_update_cnt`  out  32: number of applied training events.

## Operation
- Each entry holds: valid, tag[TAG_W], target[32], ctr[2]. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. Bits pc[1:0] are ignored.
- Lookup is combinational from registered state:
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - `bpu_predicted_pc` = target[idx] if hit && ctr[1]; otherwise if_pc + 4, with mod-2^32 wrap (0xFFFFFFFC → 0x00000000).
- Training happens at the rising edge when `bpu_write_en && !mem_stall`. Call this an "update". Cases:
  - Not a branch and hit: clear valid. This removes an alias or stale entry.
  - Not a branch and miss: no change.
  - Taken and hit: ctr saturating +1; target ← exmem_target.
  - Taken and miss: allocate by overwriting the slot: valid=1, tag, target, ctr=10.
  - Not taken and hit: ctr saturating −1; target unchanged; entry stays valid.
  - Not taken and miss: no allocation.
- `bpu_update_cnt` increments on every update, including no-change cases.
- `bpu_lookup_cnt` increments every cycle `mem_stall` is low.
- Both counters wrap modulo 2^32.

## Timing
- Prediction latency is 0 cycles; the output is combinational from `if_pc`.
- An update becomes visible to lookups in the cycle after the training edge. There is no write-to-read bypass, so a same-cycle lookup of the trained index sees the old entry.
- While `mem_stall` is high, `control_unit` holds `bpu_write_en` across the stall. Training is taken exactly once, on the first edge with `mem_stall` low. A held strobe must never double-count a counter.
- When `reset` and `bpu_write_en` arrive at the same edge, reset wins.
- Reset values, effective at the edge with `reset` high:
  - all valid = 0; all ctr = 01; tags and targets = 0.
  - both counters = 0.
  - Consequently `bpu_hit` = 0 and `bpu_predicted_pc` = if_pc + 4 from the next cycle.
- Reset asserted mid-operation discards all entries; the next cycle behaves as after power-on.

## Structure
- Shared package `bpu_pkg`:
  - Counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - Reset counter value `CTR_RESET = CTR_WNT`.
  - Allocation value `CTR_ALLOC = CTR_WT`.
  - Default `IDX_W`.
- Sub-module `sat_counter2`: a combinational next-state function with inputs cur[2] and inc and output nxt[2], saturating at 00 and 11. It is instantiated once, on the write path.
- BTB is stored as register arrays, not BRAM, so that reset clears them synchronously.

## Test plan
- Reset, then lookup with if_pc=0x00001000: requires bpu_hit=0 and predicted=0x00001004. Lookup with if_pc=0xFFFFFFFC: requires predicted=0x00000000.
- Train pc=0x00000040, taken, target=0x00000100. Next cycle, lookup 0x40: requires hit=1, predicted=0x100, ctr=10. A second taken update gives ctr=11; a third keeps ctr at 11.
- From ctr=11, send two not-taken updates. After the first, predicted is still 0x100 (ctr=10). After the second, ctr=01 and predicted=0x44.
- Alias: entry for 0x40 exists. Lookup 0x440 (same index, different tag): requires hit=0 and predicted=0x444. Then a non-branch update at 0x40: requires valid cleared and a lookup of 0x40 giving 0x44.
- Hold bpu_write_en high with mem_stall high for 3 cycles, then drop mem_stall for 1 cycle: requires exactly one update, bpu_update_cnt +1, and bpu_lookup_cnt +1 across the window.
- Assert reset on the same edge as a taken update to 0x80: requires no entry for 0x80 afterwards and both counters = 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared counter encodings and defaults for the branch predictor
package bpu_pkg;
  localparam int IDX_W_DEFAULT = 4;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;
endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// sat_counter2: 2-bit saturating counter next-state function
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = inc ? ((cur == CTR_ST) ? CTR_ST : cur + 2'd1)
              : ((cur == CTR_SNT) ? CTR_SNT : cur - 2'd1);
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters for next-PC prediction
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic [31:0] bpu_predicted_pc,
  output logic        bpu_hit,
  input  logic        bpu_write_en,
  input  logic        mem_stall,
  input  logic [31:0] exmem_pc,
  input  logic [31:0] exmem_target,
  input  logic        exmem_is_branch,
  input  logic        exmem_taken,
  output logic [31:0] bpu_lookup_cnt,
  output logic [31:0] bpu_update_cnt
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       ctr_q [N];
  logic [31:0]      lookup_cnt_q, lookup_cnt_d, update_cnt_q, update_cnt_d;
  logic [IDX_W-1:0] if_idx, wr_idx;
  logic [TAG_W-1:0] if_tag, wr_tag;
  logic             wr_hit, update, unused_bits;
  logic             wr_valid_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [31:0]      wr_tgt_d;
  logic [1:0]       wr_ctr_d, ctr_nxt;
  assign unused_bits = ^{if_pc[1:0], exmem_pc[1:0]};
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign wr_idx = exmem_pc[IDX_W+1:2];
  assign wr_tag = exmem_pc[31:IDX_W+2];
  assign bpu_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bpu_predicted_pc = (bpu_hit && ctr_q[if_idx][1]) ? tgt_q[if_idx] : if_pc + 32'd4;
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign update = bpu_write_en && !mem_stall;
  assign bpu_lookup_cnt = lookup_cnt_q;
  assign bpu_update_cnt = update_cnt_q;
  sat_counter2 u_sat (
    .cur(ctr_q[wr_idx]),
    .inc(exmem_taken),
    .nxt(ctr_nxt)
  );
  // Non-branch hits invalidate; taken misses allocate; not-taken misses leave the slot alone.
  always_comb begin
    wr_valid_d = exmem_is_branch ? (exmem_taken || valid_q[wr_idx]) : (valid_q[wr_idx] && !wr_hit);
    wr_tag_d = (exmem_is_branch && exmem_taken && !wr_hit) ? wr_tag : tag_q[wr_idx];
    wr_tgt_d = (exmem_is_branch && exmem_taken) ? exmem_target : tgt_q[wr_idx];
    wr_ctr_d = !exmem_is_branch ? ctr_q[wr_idx] : wr_hit ? ctr_nxt : exmem_taken ? CTR_ALLOC : ctr_q[wr_idx];
    lookup_cnt_d = lookup_cnt_q + {31'd0, !mem_stall};
    update_cnt_d = update_cnt_q + {31'd0, update};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_RESET;
      end
      lookup_cnt_q <= '0;
      update_cnt_q <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
      update_cnt_q <= update_cnt_d;
      if (update) begin
        valid_q[wr_idx] <= wr_valid_d;
        tag_q[wr_idx] <= wr_tag_d;
        tgt_q[wr_idx] <= wr_tgt_d;
        ctr_q[wr_idx] <= wr_ctr_d;
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed table, corner sequences and randomized model comparison
module tb_branch_predict_unit;
  logic clk = 0, reset, bpu_hit, bpu_write_en, mem_stall, exmem_is_branch, exmem_taken;
  logic [31:0] if_pc, bpu_predicted_pc, exmem_pc, exmem_target, bpu_lookup_cnt, bpu_update_cnt;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .bpu_predicted_pc(bpu_predicted_pc),
    .bpu_hit(bpu_hit), .bpu_write_en(bpu_write_en), .mem_stall(mem_stall),
    .exmem_pc(exmem_pc), .exmem_target(exmem_target), .exmem_is_branch(exmem_is_branch),
    .exmem_taken(exmem_taken), .bpu_lookup_cnt(bpu_lookup_cnt), .bpu_update_cnt(bpu_update_cnt)
  );
  typedef struct {
    logic [31:0] ip;
    logic        we;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        isb;
    logic        tk;
    logic        exp_hit;
    logic [31:0] exp_pred;
  } vec_t;
  vec_t vecs [17];
  // Reference state: plain arrays indexed by (pc/4) mod 16, tag = pc/64
  bit          m_v [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ctr [16];
  int unsigned m_lc, m_uc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask
  task automatic drive(input logic r, input logic [31:0] ip, input logic w, input logic st,
                       input logic [31:0] p, input logic [31:0] t, input logic b, input logic k);
    @(negedge clk);
    reset = r; if_pc = ip; bpu_write_en = w; mem_stall = st;
    exmem_pc = p; exmem_target = t; exmem_is_branch = b; exmem_taken = k;
    #1;
  endtask
  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[m_idx(pc)] && m_tag[m_idx(pc)] == pc / 64;
  endfunction
  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    return (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction
  task automatic model_edge(input logic r, input logic w, input logic st,
                            input logic [31:0] p, input logic [31:0] t, input logic b, input logic k);
    int unsigned i;
    bit h;
    if (r) begin
      for (int j = 0; j < 16; j++) begin m_v[j] = 0; m_tag[j] = 0; m_tgt[j] = 0; m_ctr[j] = 1; end
      m_lc = 0; m_uc = 0;
      return;
    end
    if (!st) m_lc++;
    if (!(w && !st)) return;
    m_uc++;
    i = m_idx(p);
    h = m_hit(p);
    if (!b) begin
      if (h) m_v[i] = 0;
    end else if (k) begin
      if (h) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = t;
      end else begin
        m_v[i] = 1; m_tag[i] = p / 64; m_tgt[i] = t; m_ctr[i] = 2;
      end
    end else if (h) m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
  endtask
  initial begin
    vecs[0]  = '{32'h1000,     0, 0,      0,      0, 0, 0, 32'h1004};
    vecs[1]  = '{32'hFFFFFFFC, 0, 0,      0,      0, 0, 0, 32'h0};
    vecs[2]  = '{32'h40,       1, 32'h40, 32'h100, 1, 1, 0, 32'h44};
    vecs[3]  = '{32'h40,       1, 32'h40, 32'h100, 1, 1, 1, 32'h100};
    vecs[4]  = '{32'h40,       1, 32'h40, 32'h100, 1, 1, 1, 32'h100};
    vecs[5]  = '{32'h40,       1, 32'h40, 32'h100, 1, 0, 1, 32'h100};
    vecs[6]  = '{32'h40,       1, 32'h40, 32'h100, 1, 0, 1, 32'h100};
    vecs[7]  = '{32'h40,       0, 0,      0,      0, 0, 1, 32'h44};
    vecs[8]  = '{32'h440,      1, 32'h40, 32'h100, 1, 1, 0, 32'h444};
    vecs[9]  = '{32'h40,       1, 32'h40, 0,      0, 0, 1, 32'h100};
    vecs[10] = '{32'h40,       0, 0,      0,      0, 0, 0, 32'h44};
    vecs[11] = '{32'h80,       1, 32'h80, 32'h200, 1, 1, 0, 32'h84};
    vecs[12] = '{32'h80,       1, 32'h480, 0,     0, 0, 1, 32'h200};
    vecs[13] = '{32'h80,       1, 32'hC0, 32'h700, 1, 0, 1, 32'h200};
    vecs[14] = '{32'hC0,       0, 0,      0,      0, 0, 0, 32'hC4};
    vecs[15] = '{32'h80,       1, 32'h80, 32'h300, 1, 1, 1, 32'h200};
    vecs[16] = '{32'h80,       0, 0,      0,      0, 0, 1, 32'h300};
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int v = 0; v < 17; v++) begin
      drive(0, vecs[v].ip, vecs[v].we, 0, vecs[v].pc, vecs[v].tgt, vecs[v].isb, vecs[v].tk);
      chk($sformatf("vec%0d_hit", v), {31'd0, bpu_hit}, {31'd0, vecs[v].exp_hit});
      chk($sformatf("vec%0d_pred", v), bpu_predicted_pc, vecs[v].exp_pred);
      if (v == 0) begin
        chk("reset_lookup_cnt", bpu_lookup_cnt, 0);
        chk("reset_update_cnt", bpu_update_cnt, 0);
      end
    end
    // Reset collides with a taken update while an entry for 0x80 exists
    drive(1, 32'h80, 1, 0, 32'h80, 32'h500, 1, 1);
    chk("pre_reset_lookup_cnt", bpu_lookup_cnt, 17);
    chk("pre_reset_update_cnt", bpu_update_cnt, 11);
    drive(0, 32'h80, 0, 1, 0, 0, 0, 0);
    chk("collide_hit", {31'd0, bpu_hit}, 0);
    chk("collide_pred", bpu_predicted_pc, 32'h84);
    chk("collide_lookup_cnt", bpu_lookup_cnt, 0);
    chk("collide_update_cnt", bpu_update_cnt, 0);
    // Strobe held through three stalled edges, then one unstalled edge
    drive(0, 32'h100, 1, 1, 32'h100, 32'h300, 1, 1);
    drive(0, 32'h100, 1, 1, 32'h100, 32'h300, 1, 1);
    drive(0, 32'h100, 1, 1, 32'h100, 32'h300, 1, 1);
    drive(0, 32'h100, 1, 0, 32'h100, 32'h300, 1, 1);
    chk("stall_no_early_hit", {31'd0, bpu_hit}, 0);
    drive(0, 32'h100, 0, 1, 0, 0, 0, 0);
    chk("stall_update_cnt", bpu_update_cnt, 1);
    chk("stall_lookup_cnt", bpu_lookup_cnt, 1);
    chk("stall_hit", {31'd0, bpu_hit}, 1);
    chk("stall_pred", bpu_predicted_pc, 32'h300);
    drive(0, 32'h100, 1, 0, 32'h100, 0, 1, 0);
    drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("stall_single_ctr", bpu_predicted_pc, 32'h104);
    chk("stall_update_cnt2", bpu_update_cnt, 2);
    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_edge(1, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 1500; s++) begin
      logic r, w, st, b, k;
      logic [31:0] ip, p, t;
      ip = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      p = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 40) == 0) ip = 32'hFFFFFFFC;
      t = $urandom;
      r = ($urandom_range(0, 99) == 0);
      w = $urandom_range(0, 1);
      st = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) != 0);
      k = $urandom_range(0, 1);
      drive(r, ip, w, st, p, t, b, k);
      chk("rnd_hit", {31'd0, bpu_hit}, {31'd0, m_hit(ip)});
      chk("rnd_pred", bpu_predicted_pc, m_pred(ip));
      chk("rnd_lookup_cnt", bpu_lookup_cnt, m_lc);
      chk("rnd_update_cnt", bpu_update_cnt, m_uc);
      model_edge(r, w, st, p, t, b, k);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
